// File: rtl/alu_vec_pkg.sv
// Shared definitions for the vector ALU and the logic that feeds it:
// datapath widths, ALU opcode encoding and the arbiter FSM states.
package alu_vec_pkg;

    localparam int LANES  = 16;
    localparam int LANE_W = 16;
    localparam int VEC_W  = LANES * LANE_W;
    localparam int FLAG_W = 64;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_MAX  = 3'b011,
        OP_MIN  = 3'b100,
        OP_RELU = 3'b101,
        OP_AND  = 3'b110,
        OP_PASS = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly
// after last_grant in circular order, returning both one-hot and encoded id.
module rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_valid
);

    logic            hit_hi;
    logic            hit_lo;
    logic [ID_W-1:0] id_hi;
    logic [ID_W-1:0] id_lo;

    // lowest requester above last_grant wins; otherwise wrap to the lowest overall
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        id_hi  = '0;
        id_lo  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (ID_W'(i) > last_grant) begin
                    hit_hi = 1'b1;
                    id_hi  = ID_W'(i);
                end else begin
                    hit_lo = 1'b1;
                    id_lo  = ID_W'(i);
                end
            end
        end
        grant_valid = hit_hi | hit_lo;
        grant_id    = hit_hi ? id_hi : id_lo;
        grant       = grant_valid ? (N_REQ'(1) << grant_id) : '0;
    end

endmodule

// File: rtl/alu_vec_arbiter.sv
// Time-shares one combinational vector ALU between N_REQ requesters.
// A round-robin winner's operands are registered onto the ALU, held for
// ALU_LAT cycles (multi-cycle path through the multiplier), then the result
// is captured and returned with the requester id on a valid/ready channel.
// Optional: define ALU_VEC_ARB_STATS_EN to add per-requester saturating
// completion counters on output op_count.
module alu_vec_arbiter
    import alu_vec_pkg::*;
#(
    parameter  int N_REQ   = 2,
    parameter  int ALU_LAT = 1,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*VEC_W-1:0] req_a,
    input  logic [N_REQ*VEC_W-1:0] req_b,
    input  logic [N_REQ*3-1:0]     req_opcode,
    input  logic [N_REQ-1:0]       req_scalar,
    output logic [VEC_W-1:0]       alu_a,
    output logic [VEC_W-1:0]       alu_b,
    output logic [2:0]             alu_opcode,
    output logic                   alu_flag_scalar,
    input  logic [VEC_W-1:0]       alu_result,
    input  logic [FLAG_W-1:0]      alu_flags,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [VEC_W-1:0]       rsp_result,
    output logic [FLAG_W-1:0]      rsp_flags,
    output logic                   busy
`ifdef ALU_VEC_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]    op_count
`endif
);

    arb_state_t        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [VEC_W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]        alu_opcode_q, alu_opcode_d;
    logic              alu_scalar_q, alu_scalar_d;
    logic [VEC_W-1:0]  rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_id;
    logic              grant_valid;
    logic [VEC_W-1:0]  sel_a, sel_b;
    logic [2:0]        sel_op;
    logic              sel_sc;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req         (req_valid),
        .last_grant  (last_grant_q),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // route the granted requester's operands toward the ALU input registers
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        sel_sc = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a  = req_a[i*VEC_W +: VEC_W];
                sel_b  = req_b[i*VEC_W +: VEC_W];
                sel_op = req_opcode[i*3 +: 3];
                sel_sc = req_scalar[i];
            end
        end
    end

    // grants are only offered while idle; the handshake cycle never grants
    assign req_ready = (state_q == ST_IDLE) ? grant : '0;

    // next-state and datapath capture for the IDLE -> EXEC -> RESP sequence
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        alu_scalar_d = alu_scalar_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_valid_d  = rsp_valid_q;
        busy_d       = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    alu_a_d      = sel_a;
                    alu_b_d      = sel_b;
                    alu_opcode_d = sel_op;
                    alu_scalar_d = sel_sc;
                    id_d         = grant_id;
                    cnt_d        = 3'(ALU_LAT);
                    busy_d       = 1'b1;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    last_grant_d = id_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM and all registered outputs; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            id_q         <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            alu_scalar_q <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            alu_scalar_q <= alu_scalar_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_a           = alu_a_q;
    assign alu_b           = alu_b_q;
    assign alu_opcode      = alu_opcode_q;
    assign alu_flag_scalar = alu_scalar_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_id          = id_q;
    assign rsp_result      = rsp_result_q;
    assign rsp_flags       = rsp_flags_q;
    assign busy            = busy_q;

`ifdef ALU_VEC_ARB_STATS_EN
    logic [N_REQ-1:0][15:0] count_q, count_d;

    // bump the owning requester's count on each completed response, saturating
    always_comb begin
        count_d = count_q;
        if (rsp_valid_q && rsp_ready) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (id_q == ID_W'(i) && count_q[i] != 16'hFFFF) begin
                    count_d[i] = count_q[i] + 16'd1;
                end
            end
        end
    end

    // completion counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign op_count = count_q;
`endif

endmodule

// File: tb/tb_alu_vec_arbiter.sv
// Bench for alu_vec_arbiter: a reference ALU model drives alu_result/flags,
// expected responses go to a queue when requests are accepted and are
// compared when the DUT presents them. Two instances: ALU_LAT=1 and 3.
module tb_alu_vec_arbiter;

    typedef struct packed {
        logic [0:0]   id;
        logic [255:0] res;
        logic [63:0]  flg;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [1:0]   req_valid, req_ready, req_scalar;
    logic [511:0] req_a, req_b;
    logic [5:0]   req_opcode;
    logic [255:0] alu_a, alu_b, alu_result, rsp_result;
    logic [2:0]   alu_opcode;
    logic         alu_flag_scalar, rsp_valid, rsp_ready, busy;
    logic [63:0]  alu_flags, rsp_flags;
    logic [0:0]   rsp_id;

    logic [1:0]   l3_req_valid, l3_req_ready, l3_req_scalar;
    logic [511:0] l3_req_a, l3_req_b;
    logic [5:0]   l3_req_opcode;
    logic [255:0] l3_alu_a, l3_alu_b, l3_alu_result, l3_rsp_result;
    logic [2:0]   l3_alu_opcode;
    logic         l3_alu_flag_scalar, l3_rsp_valid, l3_rsp_ready, l3_busy;
    logic [63:0]  l3_alu_flags, l3_rsp_flags;
    logic [0:0]   l3_rsp_id;
`ifdef ALU_VEC_ARB_STATS_EN
    logic [31:0]  op_count, l3_op_count;
`endif

    exp_t sb[$];
    exp_t sb3[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [255:0] model_res(input logic [255:0] a, input logic [255:0] b,
                                               input logic [2:0] op);
        logic [255:0]       r;
        logic signed [15:0] la, lb;
        logic signed [31:0] p;
        r = '0;
        for (int l = 0; l < 16; l++) begin
            la = a[l*16 +: 16];
            lb = b[l*16 +: 16];
            p  = la * lb;
            if (op == 3'b010) r[l*16 +: 16] = p[23:8];
            else              r[l*16 +: 16] = la + lb;
        end
        return r;
    endfunction

    function automatic logic [63:0] model_flg(input logic [255:0] a, input logic [255:0] b,
                                              input logic [2:0] op, input logic sc);
        return {a[63:32] ^ b[31:0], 28'h0, sc, op};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    assign alu_result    = model_res(alu_a, alu_b, alu_opcode);
    assign alu_flags     = model_flg(alu_a, alu_b, alu_opcode, alu_flag_scalar);
    assign l3_alu_result = model_res(l3_alu_a, l3_alu_b, l3_alu_opcode);
    assign l3_alu_flags  = model_flg(l3_alu_a, l3_alu_b, l3_alu_opcode, l3_alu_flag_scalar);

    alu_vec_arbiter #(.N_REQ(2), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_scalar(req_scalar),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_flag_scalar(alu_flag_scalar),
        .alu_result(alu_result), .alu_flags(alu_flags), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .busy(busy)
`ifdef ALU_VEC_ARB_STATS_EN
        , .op_count(op_count)
`endif
    );

    alu_vec_arbiter #(.N_REQ(2), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(l3_req_valid), .req_ready(l3_req_ready),
        .req_a(l3_req_a), .req_b(l3_req_b), .req_opcode(l3_req_opcode), .req_scalar(l3_req_scalar),
        .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_opcode(l3_alu_opcode),
        .alu_flag_scalar(l3_alu_flag_scalar), .alu_result(l3_alu_result),
        .alu_flags(l3_alu_flags), .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready),
        .rsp_id(l3_rsp_id), .rsp_result(l3_rsp_result), .rsp_flags(l3_rsp_flags), .busy(l3_busy)
`ifdef ALU_VEC_ARB_STATS_EN
        , .op_count(l3_op_count)
`endif
    );

    task automatic set_req(input int i, input logic [255:0] a, input logic [255:0] b,
                           input logic [2:0] op, input logic sc);
        if (i == 0) begin
            req_a[255:0] = a; req_b[255:0] = b; req_opcode[2:0] = op; req_scalar[0] = sc;
        end else begin
            req_a[511:256] = a; req_b[511:256] = b; req_opcode[5:3] = op; req_scalar[1] = sc;
        end
    endtask

    task automatic set_req3(input int i, input logic [255:0] a, input logic [255:0] b,
                            input logic [2:0] op, input logic sc);
        if (i == 0) begin
            l3_req_a[255:0] = a; l3_req_b[255:0] = b; l3_req_opcode[2:0] = op; l3_req_scalar[0] = sc;
        end else begin
            l3_req_a[511:256] = a; l3_req_b[511:256] = b; l3_req_opcode[5:3] = op; l3_req_scalar[1] = sc;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0; req_opcode = '0; req_scalar = '0;
        l3_req_valid = '0; l3_rsp_ready = 1'b0; l3_req_a = '0; l3_req_b = '0;
        l3_req_opcode = '0; l3_req_scalar = '0;
        sb.delete();
        sb3.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // waits (bounded) for a response on the chosen instance, at a falling edge
    task automatic wait_rsp(input bit third, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((third ? l3_rsp_valid : rsp_valid) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0; req_opcode = '0; req_scalar = '0;
        l3_req_valid = '0; l3_rsp_ready = 1'b0; l3_req_a = '0; l3_req_b = '0;
        l3_req_opcode = '0; l3_req_scalar = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if ({alu_a, alu_b, alu_opcode, alu_flag_scalar} !== '0) begin
            n_bad++; $display("FAIL reset_alu: got a=%h op=%h want 0", alu_a, alu_opcode); end
        n_cmp++; if ({rsp_id, rsp_result, rsp_flags} !== '0) begin
            n_bad++; $display("FAIL reset_rsp: got %h/%h want 0", rsp_result, rsp_flags); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL idle_req_ready: got %b want 00", req_ready); end
        n_cmp++; if ({busy, l3_busy, l3_rsp_valid} !== 3'b000) begin
            n_bad++; $display("FAIL idle_busy: got %b want 000", {busy, l3_busy, l3_rsp_valid}); end
    endtask

    task automatic test_single_mul();
        logic [255:0] a, b;
        exp_t e;
        do_reset();
        a = rnd256(); b = rnd256();
        a[255:240] = 16'h0180; b[255:240] = 16'hFE40;
        set_req(0, a, b, 3'b010, 1'b0);
        req_valid = 2'b01; rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_grant: got %b want 01", req_ready); end
        sb.push_back({1'b0, model_res(a, b, 3'b010), model_flg(a, b, 3'b010, 1'b0)});
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        n_cmp++; if ({busy, rsp_valid, req_ready} !== 4'b1000) begin
            n_bad++; $display("FAIL single_exec: got busy/valid/ready %b want 1000", {busy, rsp_valid, req_ready}); end
        n_cmp++; if ({alu_a, alu_b, alu_opcode} !== {a, b, 3'b010}) begin
            n_bad++; $display("FAIL single_alu_in: got op %h a %h want op 2 a %h", alu_opcode, alu_a, a); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_rsp_latency: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_result[255:240] !== 16'hFD60) begin
            n_bad++; $display("FAIL single_lane15: got %h want fd60", rsp_result[255:240]); end
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL single_rsp: got response want none queued"); end
        else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_result, rsp_flags} !== e) begin
                n_bad++; $display("FAIL single_rsp: got %h want %h", {rsp_id, rsp_result, rsp_flags}, e); end
        end
        @(negedge clk);
        n_cmp++; if ({busy, rsp_valid} !== 2'b00) begin
            n_bad++; $display("FAIL single_done: got busy/valid %b want 00", {busy, rsp_valid}); end
    endtask

    task automatic test_fairness();
        logic [255:0] fa[2][2], fb[2][2];
        logic [2:0]   fop[2][2];
        int k[2];
        int order[4];
        int n_grant, n_rsp, last_c, g, r;
        exp_t e;
        order = '{0, 1, 0, 1};
        do_reset();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                fa[i][j] = rnd256(); fb[i][j] = rnd256(); fop[i][j] = 3'(1 + i + j);
            end
        k = '{0, 0};
        set_req(0, fa[0][0], fb[0][0], fop[0][0], 1'b1);
        set_req(1, fa[1][0], fb[1][0], fop[1][0], 1'b0);
        req_valid = 2'b11; rsp_ready = 1'b1;
        n_grant = 0; n_rsp = 0; last_c = 0;
        for (int c = 0; c < 60 && n_rsp < 4; c++) begin
            #1;
            if (rsp_valid === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL fair_rsp: got response want none queued"); end
                else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_result, rsp_flags} !== e) begin
                        n_bad++; $display("FAIL fair_rsp%0d: got %h want %h", n_rsp, {rsp_id, rsp_result, rsp_flags}, e); end
                end
                n_rsp++;
            end
            if (req_ready !== 2'b00 && n_grant < 4) begin
                g = (req_ready[1] === 1'b1) ? 1 : 0;
                r = order[n_grant];
                n_cmp++; if (req_ready !== (2'b01 << r)) begin
                    n_bad++; $display("FAIL fair_grant%0d: got %b want %b", n_grant, req_ready, 2'b01 << r); end
                if (n_grant > 0) begin
                    n_cmp++; if (c - last_c != 3) begin
                        n_bad++; $display("FAIL fair_spacing%0d: got %0d want 3", n_grant, c - last_c); end
                end
                last_c = c;
                sb.push_back({1'(r), model_res(fa[r][k[r]], fb[r][k[r]], fop[r][k[r]]),
                              model_flg(fa[r][k[r]], fb[r][k[r]], fop[r][k[r]], (r == 0))});
                n_grant++;
                @(posedge clk); #1;
                k[g]++;
                if (k[g] < 2) set_req(g, fa[g][k[g]], fb[g][k[g]], fop[g][k[g]], (g == 0));
                else req_valid[g] = 1'b0;
            end else begin
                @(posedge clk);
            end
            @(negedge clk);
        end
        n_cmp++; if (n_rsp != 4) begin n_bad++; $display("FAIL fair_timeout: got %0d responses want 4", n_rsp); end
    endtask

    task automatic test_back_pressure();
        logic [255:0] a0, b0, a1, b1;
        logic [320:0] snap;
        exp_t e;
        bit ok;
        do_reset();
        a0 = rnd256(); b0 = rnd256(); a1 = rnd256(); b1 = rnd256();
        set_req(0, a0, b0, 3'b000, 1'b0);
        req_valid = 2'b01; rsp_ready = 1'b0;
        sb.push_back({1'b0, model_res(a0, b0, 3'b000), model_flg(a0, b0, 3'b000, 1'b0)});
        @(posedge clk); #1;
        set_req(1, a1, b1, 3'b010, 1'b1);
        req_valid = 2'b10;
        wait_rsp(1'b0, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL bp_rsp0: got no response want one"); end
        else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_result, rsp_flags} !== e) begin
                n_bad++; $display("FAIL bp_rsp0: got %h want %h", {rsp_id, rsp_result, rsp_flags}, e); end
        end
        snap = {rsp_id, rsp_result, rsp_flags};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, req_ready, rsp_id, rsp_result, rsp_flags} !== {1'b1, 2'b00, snap}) begin
                n_bad++; $display("FAIL bp_stall%0d: got valid %b ready %b data %h want 1 00 %h",
                                  c, rsp_valid, req_ready, {rsp_id, rsp_result, rsp_flags}, snap);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({rsp_valid, busy, req_ready} !== 4'b0010) begin
            n_bad++; $display("FAIL bp_release: got valid/busy/ready %b want 0010", {rsp_valid, busy, req_ready}); end
        sb.push_back({1'b1, model_res(a1, b1, 3'b010), model_flg(a1, b1, 3'b010, 1'b1)});
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(1'b0, ok);
        n_cmp++;
        if (!ok || sb.size() == 0) begin n_bad++; $display("FAIL bp_rsp1: got no response want one"); end
        else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_result, rsp_flags} !== e) begin
                n_bad++; $display("FAIL bp_rsp1: got %h want %h", {rsp_id, rsp_result, rsp_flags}, e); end
        end
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic [255:0] a, b;
        exp_t e;
        do_reset();
        a = rnd256(); b = rnd256();
        set_req3(0, a, b, 3'b010, 1'b1);
        l3_req_valid = 2'b01; l3_rsp_ready = 1'b1;
        #1;
        n_cmp++; if (l3_req_ready !== 2'b01) begin n_bad++; $display("FAIL lat_grant: got %b want 01", l3_req_ready); end
        sb3.push_back({1'b0, model_res(a, b, 3'b010), model_flg(a, b, 3'b010, 1'b1)});
        @(posedge clk); #1;
        l3_req_valid = 2'b00;
        set_req3(0, '0, '0, 3'b000, 1'b0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_cmp++;
            if ({l3_alu_a, l3_alu_b, l3_alu_opcode, l3_alu_flag_scalar, l3_busy, l3_rsp_valid}
                !== {a, b, 3'b010, 1'b1, 1'b1, 1'b0}) begin
                n_bad++; $display("FAIL lat_hold%0d: got op %h busy %b valid %b a %h want op 2 busy 1 valid 0 a %h",
                                  j, l3_alu_opcode, l3_busy, l3_rsp_valid, l3_alu_a, a);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (l3_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL lat_rsp: got valid %b want 1", l3_rsp_valid); end
        else begin
            e = sb3.pop_front();
            if ({l3_rsp_id, l3_rsp_result, l3_rsp_flags} !== e) begin
                n_bad++; $display("FAIL lat_rsp: got %h want %h", {l3_rsp_id, l3_rsp_result, l3_rsp_flags}, e); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_exec();
        logic [255:0] a, b, a2, b2;
        exp_t e;
        bit ok;
        do_reset();
        a = rnd256(); b = rnd256();
        set_req3(0, a, b, 3'b001, 1'b0);
        l3_req_valid = 2'b01; l3_rsp_ready = 1'b1;
        sb3.push_back({1'b0, model_res(a, b, 3'b001), model_flg(a, b, 3'b001, 1'b0)});
        @(posedge clk); #1;
        l3_req_valid = 2'b00;
        wait_rsp(1'b1, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rst_pre_rsp: got no response want one"); end
        else begin
            e = sb3.pop_front();
            if ({l3_rsp_id, l3_rsp_result, l3_rsp_flags} !== e) begin
                n_bad++; $display("FAIL rst_pre_rsp: got %h want %h", {l3_rsp_id, l3_rsp_result, l3_rsp_flags}, e); end
        end
        @(posedge clk); #1;
        set_req3(1, rnd256(), rnd256(), 3'b010, 1'b1);
        l3_req_valid = 2'b10;
        @(posedge clk); #1;
        l3_req_valid = 2'b00;
        @(negedge clk);
        n_cmp++; if (l3_busy !== 1'b1) begin n_bad++; $display("FAIL rst_in_exec: got busy %b want 1", l3_busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({l3_busy, l3_rsp_valid, l3_alu_a, l3_alu_opcode} !== '0) begin
            n_bad++; $display("FAIL rst_async: got busy %b valid %b op %h want all 0", l3_busy, l3_rsp_valid, l3_alu_opcode); end
        @(negedge clk);
        rst_n = 1'b1;
        a2 = rnd256(); b2 = rnd256();
        set_req3(0, a2, b2, 3'b000, 1'b1);
        l3_req_valid = 2'b11;
        #1;
        n_cmp++; if (l3_req_ready !== 2'b01) begin n_bad++; $display("FAIL rst_priority: got %b want 01", l3_req_ready); end
        sb3.push_back({1'b0, model_res(a2, b2, 3'b000), model_flg(a2, b2, 3'b000, 1'b1)});
        @(posedge clk); #1;
        l3_req_valid = 2'b00;
        wait_rsp(1'b1, ok);
        n_cmp++;
        if (!ok || sb3.size() == 0) begin n_bad++; $display("FAIL rst_post_rsp: got no response want one"); end
        else begin
            e = sb3.pop_front();
            if ({l3_rsp_id, l3_rsp_result, l3_rsp_flags} !== e) begin
                n_bad++; $display("FAIL rst_post_rsp: got %h want %h", {l3_rsp_id, l3_rsp_result, l3_rsp_flags}, e); end
        end
        @(negedge clk);
    endtask

`ifdef ALU_VEC_ARB_STATS_EN
    task automatic test_stats();
        logic [255:0] a, b;
        exp_t e;
        bit ok;
        do_reset();
        rsp_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            a = rnd256(); b = rnd256();
            set_req(1, a, b, 3'b000, 1'b0);
            req_valid = 2'b10;
            sb.push_back({1'b1, model_res(a, b, 3'b000), model_flg(a, b, 3'b000, 1'b0)});
            @(posedge clk); #1;
            req_valid = 2'b00;
            wait_rsp(1'b0, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL stats_rsp%0d: got no response want one", n); end
            else begin
                e = sb.pop_front();
                if ({rsp_id, rsp_result, rsp_flags} !== e) begin
                    n_bad++; $display("FAIL stats_rsp%0d: got %h want %h", n, {rsp_id, rsp_result, rsp_flags}, e); end
            end
            @(negedge clk);
        end
        n_cmp++; if (op_count !== {16'd3, 16'd0}) begin
            n_bad++; $display("FAIL stats_count: got %h want 00030000", op_count); end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_mul();
        test_fairness();
        test_back_pressure();
        test_latency();
        test_reset_mid_exec();
`ifdef ALU_VEC_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
